// File: rtl/led_matrix_pkg.sv
// Shared constants and types for the 6x6 LED matrix scan driver.
// Optional build macro used by the top level: BRIGHTNESS_PWM_EN.
package led_matrix_pkg;

    localparam int MATRIX_N = 6;
    localparam int FRAME_W  = MATRIX_N * MATRIX_N;
    localparam int ROW_W    = 3;

    // One row's worth of column bits, or one bit per row driver.
    typedef logic [MATRIX_N-1:0] line_t;

    // One-hot row select for row index r (r < MATRIX_N).
    function automatic line_t row_onehot(input logic [ROW_W-1:0] r);
        return line_t'(1) << r;
    endfunction

endpackage

// File: rtl/scan_timer.sv
// Row/column scan timebase: div counts cycles within a row period and
// row counts rows within a frame. Strobes mark the last cycle of a row
// (row_wrap) and the last cycle of a frame (frame_boundary).
module scan_timer
    import led_matrix_pkg::*;
#(
    parameter int CLK_DIV = 1000,
    parameter int DIV_W   = $clog2(CLK_DIV + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    output logic [ROW_W-1:0] row_o,
    output logic [DIV_W-1:0] div_o,
    output logic             row_wrap_o,
    output logic             frame_boundary_o
);

    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);
    localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(MATRIX_N - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic             row_wrap;
    logic             frame_boundary;

    // Next-state for the div/row counters and the wrap strobes.
    always_comb begin
        // NOTE: every comb output gets a default first, so no path can infer a latch.
        div_d          = div_q + DIV_W'(1);
        row_d          = row_q;
        row_wrap       = (div_q == DIV_MAX);
        frame_boundary = row_wrap && (row_q == ROW_MAX);
        if (row_wrap) begin
            div_d = '0;
            row_d = (row_q == ROW_MAX) ? '0 : row_q + ROW_W'(1);
        end
    end

    // Counter registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        // NOTE: non-blocking so each register samples pre-edge values regardless of statement order.
        if (rst_i) begin
            div_q <= '0;
            row_q <= '0;
        end else begin
            div_q <= div_d;
            row_q <= row_d;
        end
    end

    assign row_o            = row_q;
    assign div_o            = div_q;
    assign row_wrap_o       = row_wrap;
    assign frame_boundary_o = frame_boundary;

endmodule

// File: rtl/led_matrix_scan.sv
// Row-multiplexed 6x6 LED scan driver. Images arrive over valid/ready into
// a one-deep pending buffer and are swapped into the active frame only at
// a frame boundary, so a frame is never torn. Each row period starts with
// BLANK cycles of dark columns. All outputs are registered.
// Build macro BRIGHTNESS_PWM_EN adds a per-frame global brightness window.
module led_matrix_scan
    import led_matrix_pkg::*;
#(
    parameter int CLK_DIV        = 1000,
    parameter int BLANK          = 8,
    parameter bit ROW_ACTIVE_LOW = 1'b0,
    parameter bit COL_ACTIVE_LOW = 1'b1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [FRAME_W-1:0] img_i,
    input  logic               img_valid_i,
    output logic               img_ready_o,
    input  logic [2:0]         brightness_i,
    output logic [MATRIX_N-1:0] rows_o,
    output logic [MATRIX_N-1:0] cols_o,
    output logic               frame_start_o
);

    localparam int               DIV_W    = $clog2(CLK_DIV + 1);
    localparam logic [DIV_W-1:0] BLANK_V  = DIV_W'(BLANK);
    localparam line_t            ROW_IDLE = ROW_ACTIVE_LOW ? '1 : '0;
    localparam line_t            COL_IDLE = COL_ACTIVE_LOW ? '1 : '0;

    logic [ROW_W-1:0] row_w;
    logic [DIV_W-1:0] div_w;
    logic             row_wrap_w;
    logic             frame_boundary_w;

    scan_timer #(
        .CLK_DIV (CLK_DIV),
        .DIV_W   (DIV_W)
    ) u_timer (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .row_o            (row_w),
        .div_o            (div_w),
        .row_wrap_o       (row_wrap_w),
        .frame_boundary_o (frame_boundary_w)
    );

    logic [FRAME_W-1:0] pend_q, pend_d;
    logic               pend_full_q, pend_full_d;
    logic [FRAME_W-1:0] active_q, active_d;
    line_t              rows_q, rows_d;
    line_t              cols_q, cols_d;
    logic               frame_start_q, frame_start_d;
    logic               window_open;

`ifdef BRIGHTNESS_PWM_EN
    // Column-on threshold for brightness level b: BLANK plus (b+1)/8 of the lit span.
    function automatic logic [DIV_W-1:0] pwm_threshold(input logic [2:0] b);
        int span;
        span = ((CLK_DIV - BLANK) * (int'(b) + 1)) >> 3;
        return DIV_W'(BLANK + span);
    endfunction

    logic [2:0]       bri_q;
    logic [DIV_W-1:0] thr_q;
    logic             unused_sig;

    // Brightness level and its threshold are latched once per frame.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bri_q <= 3'd7;
            thr_q <= pwm_threshold(3'd7);
        end else if (frame_boundary_w) begin
            bri_q <= brightness_i;
            thr_q <= pwm_threshold(brightness_i);
        end
    end

    assign window_open = (div_w < thr_q);
    // row_wrap and the stored level are kept for observability only.
    assign unused_sig  = ^{row_wrap_w, bri_q};
`else
    logic unused_sig;

    assign window_open = 1'b1;
    // Brightness has no effect without the PWM build; row_wrap is observability only.
    assign unused_sig  = ^{brightness_i, row_wrap_w};
`endif

    // Pending-buffer handshake and boundary swap into the active frame.
    always_comb begin
        pend_d      = pend_q;
        pend_full_d = pend_full_q;
        active_d    = active_q;
        if (frame_boundary_w && pend_full_q) begin
            active_d    = pend_q;
            pend_full_d = 1'b0;
        end else if (img_valid_i && !pend_full_q) begin
            // Swap needs a full buffer and a handshake needs an empty one, so they never collide.
            pend_d      = img_i;
            pend_full_d = 1'b1;
        end
    end

    // Row/column drive for the current counter state, with blanking and polarity.
    always_comb begin
        line_t line;
        line = '0;
        for (int r = 0; r < MATRIX_N; r++) begin
            if (row_w == ROW_W'(r)) begin
                line = active_q[r*MATRIX_N +: MATRIX_N];
            end
        end
        if (!((div_w >= BLANK_V) && window_open)) begin
            line = '0;
        end
        rows_d        = row_onehot(row_w) ^ ROW_IDLE;
        cols_d        = line ^ COL_IDLE;
        frame_start_d = (row_w == '0) && (div_w == '0);
    end

    // Buffer and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            // NOTE: the image buffers are reset on purpose: reset must blank the display and drop any pending image.
            pend_q        <= '0;
            pend_full_q   <= 1'b0;
            active_q      <= '0;
            rows_q        <= ROW_IDLE;
            cols_q        <= COL_IDLE;
            frame_start_q <= 1'b0;
        end else begin
            pend_q        <= pend_d;
            pend_full_q   <= pend_full_d;
            active_q      <= active_d;
            rows_q        <= rows_d;
            cols_q        <= cols_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign img_ready_o   = !pend_full_q;
    assign rows_o        = rows_q;
    assign cols_o        = cols_q;
    assign frame_start_o = frame_start_q;

endmodule
